fpu_issue_ctrl: RTL and testbench

- Sequences the single-precision combinational FPU datapath between the core's FP decode stage and FP writeback.
- Accepts one operation at a time over a valid/ready request channel and registers the operands, operator and mode that drive the FPU.
- Holds those inputs stable for a per-operator multicycle latency, then captures the FPU result into a response register.
- Presents the result on a valid/ready response channel with tag passthrough and flush support.

---
 rtl/fpu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/sequencing control for a combinational single-precision FPU.
// Accepts one operation at a time and holds the FPU inputs stable for the
// operator's multicycle latency. The result is then captured and presented
// on a valid/ready response channel together with the request tag.
// Optional performance counters are enabled by defining FPU_ISSUE_PERF_CNT_EN.

package fpu_issue_ctrl_pkg;

    typedef enum logic [3:0] {
        FP_ALU_ADD    = 4'd0,
        FP_ALU_SUB    = 4'd1,
        FP_ALU_MUL    = 4'd2,
        FP_ALU_CVT    = 4'd3,
        FP_ALU_MINMAX = 4'd4,
        FP_ALU_SGNJ   = 4'd5,
        FP_ALU_CMP    = 4'd6,
        FP_ALU_CLASS  = 4'd7
    } fp_alu_op_e;

endpackage

module fpu_issue_ctrl
    import fpu_issue_ctrl_pkg::*;
#(
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CVT_LAT = 2,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             IO_CLK,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  fp_alu_op_e       req_op_i,
    input  logic [1:0]       req_mode_i,
    input  logic [31:0]      req_a_i,
    input  logic [31:0]      req_b_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output fp_alu_op_e       fpu_op_o,
    output logic [1:0]       fpu_mode_o,
    output logic [31:0]      fpu_a_o,
    output logic [31:0]      fpu_b_o,
    input  logic [31:0]      fpu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             busy_o,
    output logic [31:0]      perf_ops_o,
    output logic [31:0]      perf_stall_o
);

    localparam int unsigned MAX_AM  = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
    localparam int unsigned MAX_LAT = (MAX_AM > CVT_LAT) ? MAX_AM : CVT_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat_m1;
    logic [TAG_W-1:0] tag_q;
    logic             accept;

    // A new request is taken when idle, or when the pending response drains this cycle.
    assign req_ready_o = !flush_i && ((state == S_IDLE) || ((state == S_DONE) && rsp_ready_i));
    assign accept      = req_valid_i && req_ready_o;
    assign busy_o      = (state != S_IDLE);

    // Latency (minus one) for the operator being accepted; unlisted codes take one cycle.
    always_comb begin
        lat_m1 = '0;
        case (req_op_i)
            FP_ALU_ADD, FP_ALU_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
            FP_ALU_MUL:             lat_m1 = CNT_W'(MUL_LAT - 1);
            FP_ALU_CVT:             lat_m1 = CNT_W'(CVT_LAT - 1);
            default:                lat_m1 = '0;
        endcase
    end

    // Control FSM with registered FPU inputs and response outputs.
    // Accept is tested ahead of the state case: it can only be true in IDLE or
    // in DONE with rsp_ready_i, so this folds both accept paths into one branch.
    always_ff @(posedge IO_CLK or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            cnt          <= '0;
            tag_q        <= '0;
            fpu_op_o     <= FP_ALU_ADD;
            fpu_mode_o   <= '0;
            fpu_a_o      <= '0;
            fpu_b_o      <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_result_o <= '0;
            rsp_tag_o    <= '0;
        end else if (flush_i) begin
            state       <= S_IDLE;
            rsp_valid_o <= 1'b0;
        end else if (accept) begin
            state       <= S_EXEC;
            cnt         <= lat_m1;
            tag_q       <= req_tag_i;
            fpu_op_o    <= req_op_i;
            fpu_mode_o  <= req_mode_i;
            fpu_a_o     <= req_a_i;
            fpu_b_o     <= req_b_i;
            rsp_valid_o <= 1'b0;
        end else begin
            case (state)
                S_EXEC: begin
                    if (cnt == '0) begin
                        state        <= S_DONE;
                        rsp_valid_o  <= 1'b1;
                        rsp_result_o <= fpu_result_i;
                        rsp_tag_o    <= tag_q;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_ready_i) begin
                        state       <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FPU_ISSUE_PERF_CNT_EN
    // Completed-op and back-pressure counters; a handshake coinciding with flush is discarded.
    always_ff @(posedge IO_CLK or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_ops_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (rsp_valid_o && rsp_ready_i && !flush_i) begin
                perf_ops_o <= perf_ops_o + 32'd1;
            end
            if (rsp_valid_o && !rsp_ready_i) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`else
    assign perf_ops_o   = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: self-checking bench for fpu_issue_ctrl.
// The FPU stub only returns a valid result once its inputs have been stable for
// the operator's latency; otherwise it returns 0xDEADBEEF.
module tb_fpu_issue_ctrl;
    import fpu_issue_ctrl_pkg::*;

    localparam int unsigned TAG_W = 5;
`ifdef FPU_ISSUE_PERF_CNT_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic             IO_CLK = 1'b0;
    logic             rst_ni = 1'b0;
    logic             req_valid_i;
    logic             req_ready_o;
    fp_alu_op_e       req_op_i;
    logic [1:0]       req_mode_i;
    logic [31:0]      req_a_i;
    logic [31:0]      req_b_i;
    logic [TAG_W-1:0] req_tag_i;
    logic             flush_i;
    fp_alu_op_e       fpu_op_o;
    logic [1:0]       fpu_mode_o;
    logic [31:0]      fpu_a_o;
    logic [31:0]      fpu_b_o;
    logic [31:0]      fpu_result_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [31:0]      rsp_result_o;
    logic [TAG_W-1:0] rsp_tag_o;
    logic             busy_o;
    logic [31:0]      perf_ops_o;
    logic [31:0]      perf_stall_o;

    fpu_issue_ctrl #(
        .ADD_LAT(2),
        .MUL_LAT(3),
        .CVT_LAT(2),
        .TAG_W  (TAG_W)
    ) dut (
        .IO_CLK      (IO_CLK),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_op_i    (req_op_i),
        .req_mode_i  (req_mode_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_tag_i   (req_tag_i),
        .flush_i     (flush_i),
        .fpu_op_o    (fpu_op_o),
        .fpu_mode_o  (fpu_mode_o),
        .fpu_a_o     (fpu_a_o),
        .fpu_b_o     (fpu_b_o),
        .fpu_result_i(fpu_result_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_result_o(rsp_result_o),
        .rsp_tag_o   (rsp_tag_o),
        .busy_o      (busy_o),
        .perf_ops_o  (perf_ops_o),
        .perf_stall_o(perf_stall_o)
    );

    always #5 IO_CLK = ~IO_CLK;

    int unsigned cyc = 0;
    always @(posedge IO_CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fmodel(input fp_alu_op_e op, input logic [1:0] mode,
                                           input logic [31:0] a, input logic [31:0] b);
        if (op == FP_ALU_ADD && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == FP_ALU_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a ^ {b[15:0], b[31:16]} ^ {mode, 26'd0, op};
    endfunction

    function automatic int unsigned flat(input fp_alu_op_e op);
        case (op)
            FP_ALU_ADD, FP_ALU_SUB: return 2;
            FP_ALU_MUL:             return 3;
            FP_ALU_CVT:             return 2;
            default:                return 1;
        endcase
    endfunction

    // FPU stub: result is valid only after the inputs were stable for the op latency
    logic [69:0] snap = '1;
    int unsigned settle = 0;
    initial forever begin
        @(negedge IO_CLK);
        if ({fpu_op_o, fpu_mode_o, fpu_a_o, fpu_b_o} !== snap) begin
            snap   = {fpu_op_o, fpu_mode_o, fpu_a_o, fpu_b_o};
            settle = 1;
        end else if (settle < 16) begin
            settle++;
        end
    end
    assign fpu_result_i = (settle >= flat(fpu_op_o)) ? fmodel(fpu_op_o, fpu_mode_o, fpu_a_o, fpu_b_o)
                                                     : 32'hDEAD_BEEF;

    typedef struct {
        fp_alu_op_e       op;
        logic [1:0]       mode;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        int unsigned      lat;
        logic [31:0]      res;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int unsigned      due;
        fp_alu_op_e       op;
        logic [1:0]       mode;
        logic [31:0]      a;
        logic [31:0]      b;
    } exp_t;

    exp_t        sb[$];
    bit          seen_valid = 1'b0;
    int unsigned last_hs    = 0;

    // Flush drops everything in flight
    initial forever begin
        @(posedge IO_CLK);
        if (rst_ni && flush_i) begin
            sb.delete();
            seen_valid = 1'b0;
        end
    end

    // Response monitor: compare against scoreboard head every valid cycle
    initial forever begin
        @(negedge IO_CLK);
        if (rst_ni && rsp_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid_o=1 tag=%0d, required no response", rsp_tag_o);
            end else begin
                chk("rsp_result", rsp_result_o, sb[0].res);
                chk("rsp_tag", 32'(rsp_tag_o), 32'(sb[0].tag));
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    chk("rsp_latency", cyc, sb[0].due);
                    chk("fpu_op_held", 32'(fpu_op_o), 32'(sb[0].op));
                    chk("fpu_mode_held", 32'(fpu_mode_o), 32'(sb[0].mode));
                    chk("fpu_a_held", fpu_a_o, sb[0].a);
                    chk("fpu_b_held", fpu_b_o, sb[0].b);
                end
                if (rsp_ready_i && !flush_i) begin
                    void'(sb.pop_front());
                    seen_valid = 1'b0;
                    last_hs    = cyc + 1;
                end
            end
        end
    end

    task automatic send(input fp_alu_op_e op, input logic [1:0] mode, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag, input int unsigned lat,
                        input logic [31:0] res, output int unsigned acc_edge);
        bit   acc;
        exp_t e;
        acc         = 1'b0;
        acc_edge    = 0;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_mode_i  = mode;
        req_a_i     = a;
        req_b_i     = b;
        req_tag_i   = tag;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(posedge IO_CLK);
            if (req_ready_o) begin
                acc      = 1'b1;
                acc_edge = cyc + 1;
                e.res    = res;
                e.tag    = tag;
                e.due    = cyc + 1 + lat;
                e.op     = op;
                e.mode   = mode;
                e.a      = a;
                e.b      = b;
                sb.push_back(e);
            end
            #1;
        end
        req_valid_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: req_ready_o stayed 0, required accept within 40 cycles");
        end
    endtask

    task automatic drain(output int unsigned exec_cycles);
        exec_cycles = 0;
        for (int k = 0; k < 40 && sb.size() != 0; k++) begin
            @(negedge IO_CLK);
            if (busy_o && !rsp_valid_o) exec_cycles++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge IO_CLK);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_fpu_op", 32'(fpu_op_o), 32'(FP_ALU_ADD));
        chk("rst_fpu_mode", 32'(fpu_mode_o), 32'd0);
        chk("rst_fpu_a", fpu_a_o, 32'd0);
        chk("rst_fpu_b", fpu_b_o, 32'd0);
        chk("rst_rsp_result", rsp_result_o, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag_o), 32'd0);
        chk("rst_perf_ops", perf_ops_o, 32'd0);
        chk("rst_perf_stall", perf_stall_o, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge IO_CLK);
        rst_ni = 1'b0;
        sb.delete();
        seen_valid = 1'b0;
        #2;
        check_reset_vals();
        @(negedge IO_CLK);
        rst_ni = 1'b1;
        @(posedge IO_CLK);
        #1;
    endtask

    function automatic vec_t mk(input fp_alu_op_e op, input logic [1:0] mode, input logic [31:0] a,
                                input logic [31:0] b, input logic [TAG_W-1:0] tag, input int unsigned lat);
        vec_t v;
        v.op   = op;
        v.mode = mode;
        v.a    = a;
        v.b    = b;
        v.tag  = tag;
        v.lat  = lat;
        v.res  = fmodel(op, mode, a, b);
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[9];
        int unsigned acc1;
        int unsigned acc2;
        int unsigned ex;
        bit          got;

        tbl[0] = '{FP_ALU_ADD, 2'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 2, 32'h4040_0000};
        tbl[1] = mk(FP_ALU_SUB,    2'd1, 32'h4120_0000, 32'h3F00_0000, 5'd1, 2);
        tbl[2] = '{FP_ALU_MUL, 2'd0, 32'h4000_0000, 32'h4040_0000, 5'd17, 3, 32'h40C0_0000};
        tbl[3] = mk(FP_ALU_CVT,    2'd2, 32'h0000_0007, 32'h0000_0000, 5'd3, 2);
        tbl[4] = mk(FP_ALU_MINMAX, 2'd1, 32'hBF80_0000, 32'h3F80_0000, 5'd4, 1);
        tbl[5] = mk(FP_ALU_SGNJ,   2'd2, 32'h1234_5678, 32'h8765_4321, 5'd30, 1);
        tbl[6] = mk(FP_ALU_CMP,    2'd0, 32'h4000_0000, 32'h4000_0000, 5'd6, 1);
        tbl[7] = mk(FP_ALU_CLASS,  2'd3, 32'h7FC0_0000, 32'h0000_0000, 5'd31, 1);
        tbl[8] = mk(fp_alu_op_e'(4'hC), 2'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 5'd12, 1);

        req_valid_i = 1'b0;
        req_op_i    = FP_ALU_ADD;
        req_mode_i  = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_tag_i   = '0;
        flush_i     = 1'b0;
        rsp_ready_i = 1'b1;

        // power-on reset
        repeat (3) @(negedge IO_CLK);
        check_reset_vals();
        rst_ni = 1'b1;
        @(posedge IO_CLK);
        #1;

        // table of single operations, consumer always ready
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].op, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].lat, tbl[i].res, acc1);
            drain(ex);
            chk("exec_cycles", ex, tbl[i].lat);
        end

        // multiply under four cycles of back-pressure
        do_reset();
        rsp_ready_i = 1'b0;
        send(FP_ALU_MUL, 2'd0, 32'h4000_0000, 32'h4040_0000, 5'd9, 3, 32'h40C0_0000, acc1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge IO_CLK);
            got = rsp_valid_o;
        end
        chk("bp_rsp_seen", 32'(got), 32'd1);
        repeat (3) @(negedge IO_CLK);
        @(posedge IO_CLK);
        #1;
        rsp_ready_i = 1'b1;
        @(posedge IO_CLK);
        #1;
        chk("bp_valid_dropped", 32'(rsp_valid_o), 32'd0);
        chk("bp_perf_stall", perf_stall_o, PERF_ON ? 32'd4 : 32'd0);
        chk("bp_perf_ops", perf_ops_o, PERF_ON ? 32'd1 : 32'd0);

        // flush while a response waits, with consumer ready in the same cycle
        rsp_ready_i = 1'b0;
        send(FP_ALU_SGNJ, 2'd1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 5'd11, 1,
             fmodel(FP_ALU_SGNJ, 2'd1, 32'h0F0F_0F0F, 32'hF0F0_F0F0), acc1);
        @(posedge IO_CLK);
        #1;
        chk("done_valid", 32'(rsp_valid_o), 32'd1);
        flush_i     = 1'b1;
        rsp_ready_i = 1'b1;
        @(posedge IO_CLK);
        #1;
        flush_i = 1'b0;
        chk("done_flush_valid", 32'(rsp_valid_o), 32'd0);
        chk("done_flush_busy", 32'(busy_o), 32'd0);
        chk("done_flush_perf_ops", perf_ops_o, PERF_ON ? 32'd1 : 32'd0);

        // back-to-back CMP then CLASS
        do_reset();
        rsp_ready_i = 1'b1;
        send(FP_ALU_CMP, 2'd2, 32'h3F80_0000, 32'h4000_0000, 5'd21, 1,
             fmodel(FP_ALU_CMP, 2'd2, 32'h3F80_0000, 32'h4000_0000), acc1);
        send(FP_ALU_CLASS, 2'd0, 32'hFF80_0000, 32'h0000_0001, 5'd22, 1,
             fmodel(FP_ALU_CLASS, 2'd0, 32'hFF80_0000, 32'h0000_0001), acc2);
        chk("b2b_accept_edge", acc2, last_hs);
        chk("b2b_accept_gap", acc2 - acc1, 32'd2);
        drain(ex);
        chk("b2b_perf_ops", perf_ops_o, PERF_ON ? 32'd2 : 32'd0);

        // flush during MUL execution with a competing request
        send(FP_ALU_MUL, 2'd0, 32'h4040_0000, 32'h4080_0000, 5'd7, 3,
             fmodel(FP_ALU_MUL, 2'd0, 32'h4040_0000, 32'h4080_0000), acc1);
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_op_i    = FP_ALU_ADD;
        req_a_i     = 32'h1111_1111;
        req_b_i     = 32'h2222_2222;
        req_tag_i   = 5'd8;
        #1;
        chk("flush_blocks_ready", 32'(req_ready_o), 32'd0);
        @(posedge IO_CLK);
        #1;
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        chk("flush_idle_busy", 32'(busy_o), 32'd0);
        chk("flush_fpu_a_kept", fpu_a_o, 32'h4040_0000);
        repeat (4) @(negedge IO_CLK);
        chk("flush_still_idle", 32'(busy_o), 32'd0);
        @(posedge IO_CLK);
        #1;
        send(FP_ALU_ADD, 2'd1, 32'h0000_00FF, 32'h0000_FF00, 5'd13, 2,
             fmodel(FP_ALU_ADD, 2'd1, 32'h0000_00FF, 32'h0000_FF00), acc1);
        drain(ex);
        chk("post_flush_exec_cycles", ex, 32'd2);

        // asynchronous reset in the middle of execution
        send(FP_ALU_MUL, 2'd3, 32'h4100_0000, 32'h4100_0000, 5'd19, 3,
             fmodel(FP_ALU_MUL, 2'd3, 32'h4100_0000, 32'h4100_0000), acc1);
        #2;
        chk("mid_busy_before", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        sb.delete();
        seen_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'd1);
        chk("mid_rst_fpu_a", fpu_a_o, 32'd0);
        chk("mid_rst_perf_ops", perf_ops_o, 32'd0);
        chk("mid_rst_perf_stall", perf_stall_o, 32'd0);
        @(negedge IO_CLK);
        rst_ni = 1'b1;
        @(posedge IO_CLK);
        #1;
        send(FP_ALU_CVT, 2'd0, 32'h0000_0042, 32'h0, 5'd2, 2,
             fmodel(FP_ALU_CVT, 2'd0, 32'h0000_0042, 32'h0), acc1);
        drain(ex);
        chk("post_rst_exec_cycles", ex, 32'd2);
        chk("post_rst_perf_ops", perf_ops_o, PERF_ON ? 32'd1 : 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
